if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- IF/ID pipeline register, directly downstream of the PC register (regfilepc) in the 5-stage MIPS pipeline.
- Captures the fetched instruction, its PC and PC+8, and the fetch-stage address exception flag (PC_EXP).
- Tags branch-delay-slot instructions.
- Provides hold (stall) and bubble (flush/interrupt) control with the same stall/INT_REQ priority the PC register uses, so the two stages stay in lockstep.

Parameters:
- WIDTH, 32, datapath width of PC and instruction.
- RESET_PC, 32'h0000_3000, PC_D value after reset; matches the PC register reset value.
- EXC_ADEL, 5'd4, ExcCode reported for a fetch address error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hazard-unit stall; hold IF/ID contents
- flush  input  1  insert bubble (eret/exception redirect)
- INT_REQ  input  1  interrupt accepted; insert bubble, overrides stall
- PC_In  input  WIDTH  PC from the PC register (Data_Out)
- Instr_In  input  32  instruction word from IM at PC_In
- PC_EXP  input  1  fetch address exception from the PC register
- Is_Branch_ID  input  1  instruction currently in ID is a branch/jump
- PC_D  output  WIDTH  PC of the instruction in ID
- PC8_D  output  WIDTH  PC_D+8 (link address)
- Instr_D  output  32  instruction in ID
- Valid_D  output  1  ID slot holds a real fetched instruction
- Exc_Valid_D  output  1  ID instruction carries a fetch exception
- ExcCode_D  output  5  exception code for the ID instruction
- BD_D  output  1  ID instruction is in a branch delay slot

Behaviour:
- Async reset (reset high, no clock needed):
  - PC_D = RESET_PC, PC8_D = RESET_PC+8, Instr_D = 0.
  - Valid_D = 0, Exc_Valid_D = 0, ExcCode_D = 0, BD_D = 0.
  - Deasserting reset does not change the outputs until the next qualifying edge.
- Per rising edge, priority is reset > (INT_REQ | flush) > stall > load.
- BUBBLE (INT_REQ | flush), regardless of stall:
  - Instr_D = 0, Valid_D = 0, Exc_Valid_D = 0, ExcCode_D = 0, BD_D = 0.
  - PC_D <= PC_In and PC8_D <= PC_In+8, so EPC logic sees the redirect PC.
- HOLD (stall, no bubble): all outputs keep their value, including BD_D. Is_Branch_ID is ignored.
- LOAD (no stall, no bubble): PC_D <= PC_In, PC8_D <= PC_In+8 (mod 2^WIDTH, wraps silently), Valid_D <= 1, BD_D <= Is_Branch_ID.
  - If PC_EXP = 1: Instr_D <= 0 (nop, so the bogus IM word never decodes), Exc_Valid_D <= 1, ExcCode_D <= EXC_ADEL.
  - If PC_EXP = 0: Instr_D <= Instr_In, Exc_Valid_D <= 0, ExcCode_D <= 0.
- Latency: 1 cycle from IF inputs to D outputs. No combinational path from any input to any output.
- Stall for N cycles, then release: the held instruction stays in ID for exactly N+1 cycles and is never duplicated or dropped.
- flush and INT_REQ asserted together: a single bubble, identical to either one alone.
- Reset asserted mid-stall or mid-bubble: immediate return to reset values. The first edge after reset release performs a LOAD if stall = 0.

Optional Feature:
- Macro IFID_STALL_CNT_EN.
- Defined:
  - Adds output Stall_Cnt [15:0], reset to 0.
  - Increments on each edge where the HOLD action is taken; saturates at 16'hFFFF.
  - Not cleared by flush or INT_REQ.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset between edges -> outputs immediately PC_D=32'h3000, PC8_D=32'h3008, Instr_D=0, Valid_D=0.
- Load: PC_In=32'h3004, Instr_In=32'h2408_0005, PC_EXP=0 -> next edge PC_D=32'h3004, PC8_D=32'h300C, Instr_D=32'h2408_0005, Valid_D=1, Exc_Valid_D=0.
- Fetch exception: PC_In=32'h3002, PC_EXP=1, Instr_In=32'hFFFF_FFFF -> Instr_D=0, Exc_Valid_D=1, ExcCode_D=4, PC_D=32'h3002.
- Stall then interrupt: stall=1 for 3 edges with changing inputs -> outputs frozen (Stall_Cnt=3 if IFID_STALL_CNT_EN). Then INT_REQ=1 with stall=1, PC_In=32'h4180 -> Instr_D=0, Valid_D=0, PC_D=32'h4180.
- Delay slot: Is_Branch_ID=1 on a LOAD edge -> BD_D=1. Next LOAD edge with Is_Branch_ID=0 -> BD_D=0. flush on a LOAD edge with Is_Branch_ID=1 -> BD_D=0.
- Counter saturation (IFID_STALL_CNT_EN): 65540 consecutive stall cycles -> Stall_Cnt=16'hFFFF. One flush cycle follows -> Stall_Cnt still 16'hFFFF.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction, its PC/PC+8, fetch exception and delay-slot tag.
// Optional hold-cycle counter output Stall_Cnt is built when IFID_STALL_CNT_EN is defined.
module if_id_reg #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [4:0]       EXC_ADEL = 5'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             INT_REQ,
  input  logic [WIDTH-1:0] PC_In,
  input  logic [31:0]      Instr_In,
  input  logic             PC_EXP,
  input  logic             Is_Branch_ID,
  output logic [WIDTH-1:0] PC_D,
  output logic [WIDTH-1:0] PC8_D,
  output logic [31:0]      Instr_D,
  output logic             Valid_D,
  output logic             Exc_Valid_D,
  output logic [4:0]       ExcCode_D,
  output logic             BD_D
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0]      Stall_Cnt
`endif
);

  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] pc8_reg, pc8_next;
  logic [31:0]      instr_reg, instr_next;
  logic             valid_reg, valid_next;
  logic             exc_valid_reg, exc_valid_next;
  logic [4:0]       exc_code_reg, exc_code_next;
  logic             bd_reg, bd_next;

  logic bubble;
  logic hold;

  // Interrupt/flush wins over stall so this stage tracks the PC register exactly.
  assign bubble = INT_REQ | flush;
  assign hold   = stall & ~bubble;

  always_comb begin
    pc_next        = pc_reg;
    pc8_next       = pc8_reg;
    instr_next     = instr_reg;
    valid_next     = valid_reg;
    exc_valid_next = exc_valid_reg;
    exc_code_next  = exc_code_reg;
    bd_next        = bd_reg;
    if (bubble) begin
      pc_next        = PC_In;
      pc8_next       = PC_In + WIDTH'(8);
      instr_next     = 32'd0;
      valid_next     = 1'b0;
      exc_valid_next = 1'b0;
      exc_code_next  = 5'd0;
      bd_next        = 1'b0;
    end else if (!stall) begin
      pc_next    = PC_In;
      pc8_next   = PC_In + WIDTH'(8);
      valid_next = 1'b1;
      bd_next    = Is_Branch_ID;
      // A faulting fetch enters ID as a nop so the bogus IM word never decodes.
      if (PC_EXP) begin
        instr_next     = 32'd0;
        exc_valid_next = 1'b1;
        exc_code_next  = EXC_ADEL;
      end else begin
        instr_next     = Instr_In;
        exc_valid_next = 1'b0;
        exc_code_next  = 5'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg        <= RESET_PC;
      pc8_reg       <= RESET_PC + WIDTH'(8);
      instr_reg     <= 32'd0;
      valid_reg     <= 1'b0;
      exc_valid_reg <= 1'b0;
      exc_code_reg  <= 5'd0;
      bd_reg        <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      pc8_reg       <= pc8_next;
      instr_reg     <= instr_next;
      valid_reg     <= valid_next;
      exc_valid_reg <= exc_valid_next;
      exc_code_reg  <= exc_code_next;
      bd_reg        <= bd_next;
    end
  end

  assign PC_D        = pc_reg;
  assign PC8_D       = pc8_reg;
  assign Instr_D     = instr_reg;
  assign Valid_D     = valid_reg;
  assign Exc_Valid_D = exc_valid_reg;
  assign ExcCode_D   = exc_code_reg;
  assign BD_D        = bd_reg;

`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt_reg, stall_cnt_next;

  // Counts hold edges only; saturates and survives bubbles.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (hold && stall_cnt_reg != 16'hFFFF)
      stall_cnt_next = stall_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_reg <= 16'd0;
    else       stall_cnt_reg <= stall_cnt_next;
  end

  assign Stall_Cnt = stall_cnt_reg;
`else
  logic unused_hold;
  assign unused_hold = hold;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: a spec-level model pushes expected ID state per edge, popped and compared after the edge.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        INT_REQ = 1'b0;
  logic [31:0] PC_In = 32'd0;
  logic [31:0] Instr_In = 32'd0;
  logic        PC_EXP = 1'b0;
  logic        Is_Branch_ID = 1'b0;
  logic [31:0] PC_D, PC8_D, Instr_D;
  logic        Valid_D, Exc_Valid_D, BD_D;
  logic [4:0]  ExcCode_D;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] Stall_Cnt;
`endif

  if_id_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .INT_REQ(INT_REQ),
    .PC_In(PC_In), .Instr_In(Instr_In), .PC_EXP(PC_EXP), .Is_Branch_ID(Is_Branch_ID),
    .PC_D(PC_D), .PC8_D(PC8_D), .Instr_D(Instr_D), .Valid_D(Valid_D),
    .Exc_Valid_D(Exc_Valid_D), .ExcCode_D(ExcCode_D), .BD_D(BD_D)
`ifdef IFID_STALL_CNT_EN
    , .Stall_Cnt(Stall_Cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] instr;
    logic        valid;
    logic        exv;
    logic [4:0]  code;
    logic        bd;
    logic [15:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int step_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m.pc = 32'h0000_3000; m.pc8 = 32'h0000_3008; m.instr = 32'd0;
    m.valid = 1'b0; m.exv = 1'b0; m.code = 5'd0; m.bd = 1'b0; m.cnt = 16'd0;
    sb_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, PC_D, 32'h0000_3000);
    check({tag, "_pc8"}, PC8_D, 32'h0000_3008);
    check({tag, "_instr"}, Instr_D, 32'd0);
    check({tag, "_valid"}, {31'd0, Valid_D}, 32'd0);
    check({tag, "_exv"}, {31'd0, Exc_Valid_D}, 32'd0);
    check({tag, "_code"}, {27'd0, ExcCode_D}, 32'd0);
    check({tag, "_bd"}, {31'd0, BD_D}, 32'd0);
`ifdef IFID_STALL_CNT_EN
    check({tag, "_cnt"}, {16'd0, Stall_Cnt}, 32'd0);
`endif
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_pc"}, PC_D, e.pc);
    check({tag, "_pc8"}, PC8_D, e.pc8);
    check({tag, "_instr"}, Instr_D, e.instr);
    check({tag, "_valid"}, {31'd0, Valid_D}, {31'd0, e.valid});
    check({tag, "_exv"}, {31'd0, Exc_Valid_D}, {31'd0, e.exv});
    check({tag, "_code"}, {27'd0, ExcCode_D}, {27'd0, e.code});
    check({tag, "_bd"}, {31'd0, BD_D}, {31'd0, e.bd});
`ifdef IFID_STALL_CNT_EN
    check({tag, "_cnt"}, {16'd0, Stall_Cnt}, {16'd0, e.cnt});
`endif
  endtask

  // Drive one edge's inputs, predict the ID state, clock, then compare.
  task automatic step(input string tag, input logic st, input logic fl, input logic ir,
                      input logic [31:0] pc, input logic [31:0] ins, input logic ex, input logic br);
    stall = st; flush = fl; INT_REQ = ir; PC_In = pc; Instr_In = ins; PC_EXP = ex; Is_Branch_ID = br;
    if (ir || fl) begin
      m.pc = pc; m.pc8 = pc + 32'd8; m.instr = 32'd0;
      m.valid = 1'b0; m.exv = 1'b0; m.code = 5'd0; m.bd = 1'b0;
    end else if (st) begin
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
    end else begin
      m.pc = pc; m.pc8 = pc + 32'd8; m.valid = 1'b1; m.bd = br;
      m.instr = ex ? 32'd0 : ins;
      m.exv = ex;
      m.code = ex ? 5'd4 : 5'd0;
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    compare_pop(tag);
    step_no++;
    $display("step %0d %s st=%b fl=%b ir=%b pc_in=%h -> PC_D=%h PC8_D=%h Instr_D=%h V=%b EXV=%b BD=%b",
             step_no, tag, st, fl, ir, pc, PC_D, PC8_D, Instr_D, Valid_D, Exc_Valid_D, BD_D);
  endtask

  initial begin
    model_reset();
    // Reset asserted between edges must take effect without a clock.
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_async");
    @(posedge clk); #1;
    reset = 1'b0;
    #1 check_reset_vals("rst_release");

    step("load", 1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h2408_0005, 1'b0, 1'b0);
    check("load_pc8_const", PC8_D, 32'h0000_300C);
    step("fetch_exc", 1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("fetch_exc_code_const", {27'd0, ExcCode_D}, 32'd4);

    step("stall1", 1'b1, 1'b0, 1'b0, 32'h0000_3010, 32'h1111_1111, 1'b0, 1'b1);
    step("stall2", 1'b1, 1'b0, 1'b0, 32'h0000_3014, 32'h2222_2222, 1'b1, 1'b0);
    step("stall3", 1'b1, 1'b0, 1'b0, 32'h0000_3018, 32'h3333_3333, 1'b0, 1'b1);
`ifdef IFID_STALL_CNT_EN
    check("stall_cnt_3", {16'd0, Stall_Cnt}, 32'd3);
`endif
    step("int_over_stall", 1'b1, 1'b0, 1'b1, 32'h0000_4180, 32'h4444_4444, 1'b0, 1'b1);
    check("int_pc_const", PC_D, 32'h0000_4180);

    step("bd_set", 1'b0, 1'b0, 1'b0, 32'h0000_4184, 32'h1000_0003, 1'b0, 1'b1);
    step("bd_clear", 1'b0, 1'b0, 1'b0, 32'h0000_4188, 32'h0000_0000, 1'b0, 1'b0);
    step("bd_set2", 1'b0, 1'b0, 1'b0, 32'h0000_418C, 32'h0800_0c00, 1'b0, 1'b1);
    step("flush_bd", 1'b0, 1'b1, 1'b0, 32'h0000_4190, 32'h5555_5555, 1'b0, 1'b1);
    step("reload", 1'b0, 1'b0, 1'b0, 32'h0000_4194, 32'h3c01_1234, 1'b0, 1'b0);
    step("flush_and_int", 1'b0, 1'b1, 1'b1, 32'h0000_4198, 32'h6666_6666, 1'b0, 1'b1);
    step("pc_wrap", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0123_4567, 1'b0, 1'b0);
    check("pc_wrap_const", PC8_D, 32'h0000_0004);

    // Stall two edges then release: instruction held, next one loads once.
    step("hold_a", 1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'hAAAA_0001, 1'b0, 1'b0);
    step("hold_b", 1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'hAAAA_0001, 1'b0, 1'b0);
    step("release", 1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'hAAAA_0001, 1'b0, 1'b0);
    step("next", 1'b0, 1'b0, 1'b0, 32'h0000_5004, 32'hAAAA_0002, 1'b0, 1'b0);

    // Reset in the middle of a stall.
    step("pre_rst_stall", 1'b1, 1'b0, 1'b0, 32'h0000_6000, 32'hBBBB_0000, 1'b0, 1'b1);
    reset = 1'b1;
    #1 check_reset_vals("rst_mid_stall");
    model_reset();
    @(posedge clk); #1;
    stall = 1'b0;
    reset = 1'b0;
    #1 check_reset_vals("rst_mid_release");
    step("post_rst_load", 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h2402_000a, 1'b0, 1'b0);

`ifdef IFID_STALL_CNT_EN
    stall = 1'b1; flush = 1'b0; INT_REQ = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    m.cnt = 16'hFFFF;
    check("sat_cnt", {16'd0, Stall_Cnt}, 32'h0000_FFFF);
    check("sat_instr_held", Instr_D, m.instr);
    $display("long stall 65540 cycles -> Stall_Cnt=%h", Stall_Cnt);
    step("sat_flush", 1'b0, 1'b1, 1'b0, 32'h0000_7000, 32'hCCCC_0000, 1'b0, 1'b0);
`endif

    check("queue_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
